// File: rtl/popcount_seq_pkg.sv
// popcount_seq_pkg: shared widths and FSM encoding for the popcount sequencer
package popcount_seq_pkg;
  localparam int CHUNK_W = 7;
  localparam int CW = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/popcount_sequencer_ones.sv
// ones_counter_7: combinational count of set bits in a 7-bit chunk
module ones_counter_7
  import popcount_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] chunk,
  output logic [CW-1:0]      ones
);
  always_comb begin
    ones = '0;
    for (int i = 0; i < CHUNK_W; i++) ones = ones + {{(CW-1){1'b0}}, chunk[i]};
  end
endmodule

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: counts ones in a wide word, one 7-bit chunk per clock
module popcount_sequencer
  import popcount_seq_pkg::*;
#(
  parameter int CHUNKS = 4,
  parameter int CNT_W = $clog2(7*CHUNKS+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7*CHUNKS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_count,
  output logic                  busy
);
  localparam int IDX_W = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS-1);
  state_e state_q, state_d;
  logic [7*CHUNKS-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d, sum;
  logic [CHUNK_W-1:0] chunk;
  logic [CW-1:0] ones;
  assign chunk = CHUNK_W'(data_q >> (CHUNK_W * int'(idx_q)));
  ones_counter_7 u_ones (.chunk(chunk), .ones(ones));
  assign sum = acc_q + CNT_W'(ones);
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    idx_d = idx_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d = in_data;
        acc_d = '0;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = sum;
        idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
        cnt_d = idx_q == LAST ? sum : cnt_q;
        state_d = idx_q == LAST ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == RUN || state_q == DONE;
  assign out_count = cnt_q;
endmodule
